// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and
// frame constants, common to the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial input and received-byte outputs of the UART receiver.
// master drives rx and observes the byte stream; slave is the receiver.
interface uart_receiver_if;

    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       led;

    modport master (
        output rx,
        input  data, valid, frame_err, busy, led
    );

    modport slave (
        input  rx,
        output data, valid, frame_err, busy, led
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the rx pin plus falling-edge detect.
// All flops reset to 1 so an idle line never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_rx;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rx_s = r_s2;
    assign o_fall = r_prev & ~r_s2;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and 1-cycle valid/frame_err strobes.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 voting around each sample point.
import uart_pkg::*;

module uart_receiver #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input logic       clk,
    input logic       rst_n,
    uart_receiver_if.slave bus
);

    localparam int MID = CLKS_PER_BIT / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif
    localparam logic [CNT_W-1:0] START_AT = CNT_W'(MID - 1 + LAG);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_e      r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]       r_idx, w_idx_n;
    logic [7:0]       r_shift, w_shift_n;
    logic [7:0]       r_data, w_data_n;
    logic             r_valid, w_valid_n;
    logic             r_ferr, w_ferr_n;
    logic             r_led, w_led_n;

    logic w_rx_s;
    logic w_fall;
    logic w_bit;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rx   (bus.rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

`ifdef RX_MAJORITY_VOTE_EN
    // Decision lands one cycle after nominal: history holds offsets -1 and 0.
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= 2'b11;
        else        r_hist <= {r_hist[0], w_rx_s};
    end

    assign w_bit = (r_hist[1] & r_hist[0]) |
                   (r_hist[1] & w_rx_s)    |
                   (r_hist[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_shift_n = r_shift;
        w_data_n  = r_data;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        w_led_n   = r_led;
        unique case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_n = START;
                    w_cnt_n   = '0;
                end
            end
            START: begin
                if (r_cnt == START_AT) begin
                    w_cnt_n = '0;
                    w_idx_n = '0;
                    w_state_n = w_bit ? IDLE : DATA;
                end else begin
                    w_cnt_n = r_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_n          = '0;
                    w_shift_n[r_idx] = w_bit;
                    if (r_idx == LAST_IDX) w_state_n = STOP;
                    else                   w_idx_n   = r_idx + 3'd1;
                end else begin
                    w_cnt_n = r_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_n   = '0;
                    w_state_n = IDLE;
                    if (w_bit) begin
                        w_data_n  = r_shift;
                        w_valid_n = 1'b1;
                        w_led_n   = ~r_led;
                    end else begin
                        w_ferr_n  = 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + CNT_ONE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_shift <= w_shift_n;
            r_data  <= w_data_n;
            r_valid <= w_valid_n;
            r_ferr  <= w_ferr_n;
            r_led   <= w_led_n;
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != IDLE);
    assign bus.led       = r_led;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated bit by bit at
// 16 clk/bit, expected bytes queued, and a monitor checks every output pulse.
module tb_uart_receiver;

    localparam int CPB = 16;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
        logic       led;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    uart_receiver_if bus ();

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_led  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] b, input logic stopb);
        exp_t e;
        if (stopb) begin
            m_data = b;
            m_led  = ~m_led;
            e = '{err: 1'b0, data: b, led: m_led};
        end else begin
            e = '{err: 1'b1, data: m_data, led: m_led};
        end
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        push_frame(b, stopb);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stopb, CPB);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, q.size(), 0);
        q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},  bus.data, 8'h00);
        chk({tag, "_valid"}, bus.valid, 1'b0);
        chk({tag, "_ferr"},  bus.frame_err, 1'b0);
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_led"},   bus.led, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.valid || bus.frame_err)) begin
            chk("exclusive", {31'd0, bus.valid & bus.frame_err}, 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious: got valid=%0b frame_err=%0b data=%0h expected no pulse at %0t",
                         bus.valid, bus.frame_err, bus.data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("kind", bus.frame_err, e.err);
                chk("data", bus.data, e.data);
                chk("led",  bus.led, e.led);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       s;
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        hold(1'b1, 20);
        chk_reset_outputs("idle");

        send_frame(8'hA5, 1'b1);
        hold(1'b1, 20);
        drain("a5");

        hold(1'b0, 3);
        hold(1'b1, 9);
        chk("glitch_busy", bus.busy, 1'b0);
        hold(1'b1, 20);
        drain("glitch");

        send_frame(8'h3C, 1'b0);
        hold(1'b0, 40);
        chk("break_busy", bus.busy, 1'b0);
        hold(1'b1, 20);
        drain("ferr");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 20);
        drain("b2b");
        chk("b2b_led", bus.led, 1'b1);

        b = 8'h55;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b[i], CPB);
        hold(b[4], 8);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        m_data = 8'h00;
        m_led  = 1'b0;
        q.delete();
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(1'b1, 20);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 20);
        drain("r81");

`ifdef RX_MAJORITY_VOTE_EN
        push_frame(8'h00, 1'b1);
`else
        push_frame(8'h08, 1'b1);
`endif
        hold(1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(1'b0, CPB);
        hold(1'b0, 8);
        hold(1'b1, 1);
        hold(1'b0, 7);
        for (int i = 4; i < 8; i++) hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b1, 20);
        drain("vote");

        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s);
            hold(1'b1, s ? $urandom_range(0, 10) : $urandom_range(1, 10));
        end
        hold(1'b1, 20);
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
